cdc_pattern_generator: RTL

CDC_PATTERN_GENERATOR -- requirements
Module: cdc_pattern_generator

---
 rtl/cdc_pattern_generator_if.sv | 29 ++
 rtl/cdc_pattern_generator.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cdc_pattern_generator_if.sv
// Run control, timing config and pattern outputs of the capture pattern generator.
// Plain signal bundle: no latency, no backpressure.
// master drives start/config and observes the pattern; slave is the generator.
interface cdc_pattern_generator_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              start_not_stop;
    logic [CNT_W-1:0]  cfg_cycle_len;
    logic [CNT_W-1:0]  cfg_edge_cycle;
    logic [CNT_W-1:0]  cfg_data_cycle;
    logic [1:0]        cfg_mode;
    logic [DATA_W-1:0] cfg_seed;
    logic [DATA_W-1:0] capture_data;
    logic              capture_edge;
    logic              running;
    logic [15:0]       period_count;
    logic              cfg_error;

    modport master (
        output start_not_stop, cfg_cycle_len, cfg_edge_cycle, cfg_data_cycle, cfg_mode, cfg_seed,
        input  capture_data, capture_edge, running, period_count, cfg_error
    );

    modport slave (
        input  start_not_stop, cfg_cycle_len, cfg_edge_cycle, cfg_data_cycle, cfg_mode, cfg_seed,
        output capture_data, capture_edge, running, period_count, cfg_error
    );
endinterface

// File: rtl/cdc_pattern_generator.sv
// Periodic capture-strobe and data-pattern generator, started/stopped by an async request.
// Latency: run request to running = SYNC_STAGES sync flops + one LOAD cycle; outputs registered.
// No backpressure: a stop request always completes the current period before going idle.
module cdc_pattern_generator #(
    parameter int                 DATA_W      = 8,
    parameter int                 CNT_W       = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]  LFSR_TAPS   = 8'hB8
) (
    input  logic                    clk,
    input  logic                    reset,
    cdc_pattern_generator_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

    localparam logic [DATA_W-1:0] DATA_RST = {(DATA_W/2){2'b01}};

    state_t             state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               start_s;

    logic [CNT_W-1:0]   len_q, edge_cyc_q, data_cyc_q, cycle_q;
    logic [1:0]         mode_q;
    logic [DATA_W-1:0]  seed_q, data_q, data_nxt, seed_fix;
    logic               strobe_q, err_q, err_set;
    logic [15:0]        period_q;
    logic               cfg_ok, active, wrap, accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.start_not_stop};
    end
    assign start_s = sync_q[SYNC_STAGES-1];

    assign cfg_ok = (bus.cfg_cycle_len != '0) &&
                    (bus.cfg_edge_cycle < bus.cfg_cycle_len) &&
                    (bus.cfg_data_cycle < bus.cfg_cycle_len);
    assign active = (state == RUN) || (state == FINISH);
    assign wrap   = active && (cycle_q == len_q - CNT_W'(1));
    assign accept = (state == IDLE) && (state_nxt == LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A renewed run request inside FINISH takes priority over the period-end exit.
    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start_s) begin
                    if (cfg_ok) state_nxt = LOAD;
                    else        err_set   = 1'b1;
                end
            end
            LOAD:    state_nxt = RUN;
            RUN:     if (!start_s) state_nxt = FINISH;
            FINISH: begin
                if (start_s)   state_nxt = RUN;
                else if (wrap) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_nxt = data_q;
        case (mode_q)
            2'd0:    data_nxt = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
            2'd1:    data_nxt = (data_q >> 1) ^ (data_q[0] ? LFSR_TAPS : '0);
            2'd2:    data_nxt = data_q + DATA_W'(1);
            default: data_nxt = data_q;
        endcase
    end

    // Walking-one and LFSR would lock up on an all-zero word.
    assign seed_fix = ((mode_q[1] == 1'b0) && (seed_q == '0)) ? DATA_W'(1) : seed_q;

    // Config is captured on the same edge it is validated so LOAD never sees a different one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            edge_cyc_q <= '0;
            data_cyc_q <= '0;
            mode_q     <= '0;
            seed_q     <= '0;
        end else if (accept) begin
            len_q      <= bus.cfg_cycle_len;
            edge_cyc_q <= bus.cfg_edge_cycle;
            data_cyc_q <= bus.cfg_data_cycle;
            mode_q     <= bus.cfg_mode;
            seed_q     <= bus.cfg_seed;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= DATA_RST;
            strobe_q <= 1'b0;
            cycle_q  <= '0;
            period_q <= '0;
            err_q    <= 1'b0;
        end else if (state == LOAD) begin
            data_q   <= seed_fix;
            cycle_q  <= '0;
            period_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (err_set) err_q <= 1'b1;
            if (active) begin
                if (cycle_q == edge_cyc_q) strobe_q <= ~strobe_q;
                if (cycle_q == data_cyc_q) data_q   <= data_nxt;
                if (wrap) begin
                    cycle_q <= '0;
                    if (period_q != 16'hFFFF) period_q <= period_q + 16'd1;
                end else begin
                    cycle_q <= cycle_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.capture_data = data_q;
    assign bus.capture_edge = strobe_q;
    assign bus.running      = active;
    assign bus.period_count = period_q;
    assign bus.cfg_error    = err_q;

endmodule
